// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative 32-bit multiply/divide unit owning the HI/LO architectural
// registers. One launched operation runs 32 single-bit iterations (shift-add
// multiply or restoring divide) on operand magnitudes, then a finishing cycle
// applies the sign fixup and writes HI/LO. Divide-by-zero skips the iterations
// and spends two cycles in FINISH before writing HI = opA, LO = all ones.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      launch operation (sampled only in IDLE)
//   op[1:0]    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opA[31:0]  rs data: multiplicand / dividend, also mthi/mtlo data
//   opB[31:0]  rt data: multiplier / divisor
//   mthi, mtlo direct HI/LO write strobes (IDLE only, lower priority than start)
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse in the cycle HI/LO hold a new result
//   hi, lo     HI/LO architectural registers
// -----------------------------------------------------------------------------
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    // Control state
    state_e      state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic        done_q,    done_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;

    // Per-operation datapath state
    logic        is_div_q,  is_div_d;
    logic        div0_q,    div0_d;
    logic        hold_q,    hold_d;     // extra FINISH cycle for divide-by-zero
    logic        neg_res_q, neg_res_d;  // product sign, or quotient sign
    logic        neg_rem_q, neg_rem_d;  // remainder takes the dividend's sign
    logic [31:0] opnd_q,    opnd_d;     // multiplicand magnitude, or divisor magnitude
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits becoming quotient bits}.
    logic [63:0] acc_q,     acc_d;

    // Combinational helpers
    logic        signed_op;
    logic        div_by_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] add_sum;
    logic [32:0] sub_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        hold_d    = hold_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;

        signed_op   = ~op[0];
        div_by_zero = op[1] && (opB == 32'd0);
        mag_a       = (signed_op && opA[31]) ? (~opA + 32'd1) : opA;
        mag_b       = (signed_op && opB[31]) ? (~opB + 32'd1) : opB;

        // One shift-add step: add multiplicand if the current multiplier bit
        // is set, then shift the whole accumulator right (carry included).
        add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        // One restoring step: trial-subtract divisor from {remainder, next bit};
        // bit 32 set means borrow, i.e. the divisor did not fit.
        sub_diff = acc_q[63:31] - {1'b0, opnd_q};

        prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
        quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // start wins over mthi/mtlo arriving on the same edge
                    is_div_d  = op[1];
                    div0_d    = div_by_zero;
                    neg_rem_d = signed_op && opA[31];
                    neg_res_d = signed_op && (opA[31] ^ opB[31]);
                    cnt_d     = 5'd0;
                    if (div_by_zero) begin
                        acc_d   = {32'd0, opA};   // raw dividend becomes HI
                        hold_d  = 1'b1;
                        state_d = S_FINISH;
                    end else if (op[1]) begin
                        opnd_d  = mag_b;
                        acc_d   = {32'd0, mag_a};
                        state_d = S_CALC;
                    end else begin
                        opnd_d  = mag_a;
                        acc_d   = {32'd0, mag_b};
                        state_d = S_CALC;
                    end
                end else begin
                    if (mthi) hi_d = opA;
                    if (mtlo) lo_d = opA;
                end
            end

            S_CALC: begin
                if (is_div_q) begin
                    if (!sub_diff[32]) acc_d = {sub_diff[31:0], acc_q[30:0], 1'b1};
                    else               acc_d = {acc_q[62:0], 1'b0};
                end else begin
                    acc_d = {add_sum, acc_q[31:1]};
                end
                if (cnt_q == 5'd31) begin
                    cnt_d   = 5'd0;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_FINISH: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (div0_q) begin
                        hi_d = acc_q[31:0];
                        lo_d = 32'hFFFF_FFFF;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the per-operation datapath registers are not reset; they are
        // always loaded on the launch edge before anything reads them.
        is_div_q  <= is_div_d;
        div0_q    <= div0_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        opnd_q    <= opnd_d;
        acc_q     <= acc_d;

        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from values sampled before the edge.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
            hold_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
